v_instr_issue_queue: RTL and testbench

Show-ahead FIFO between the scalar core's vector-instruction issue point and the vector core's instruction/operand inputs. Buffers each vector instruction with its scalar operands (rs1, rs2) so the scalar core keeps issuing while the vector core is stalled. Tracks queued vector memory instructions and stalls scalar loads/stores until those have been handed to the vector core.

---
 rtl/v_instr_issue_queue.sv | 134 +++++++++++++
 tb/tb_v_instr_issue_queue.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/v_instr_issue_queue.sv
// Show-ahead issue queue carrying vector instructions and their scalar operands
// from the scalar core to the vector core, with vector memory-op stall tracking.
module v_instr_issue_queue #(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          instr_valid_i,
  input  logic [DATA_WIDTH-1:0]         vector_instruction_i,
  input  logic [DATA_WIDTH-1:0]         rs1_i,
  input  logic [DATA_WIDTH-1:0]         rs2_i,
  output logic                          instr_ready_o,
  input  logic                          flush_i,
  input  logic                          scalar_load_req_i,
  input  logic                          scalar_store_req_i,
  output logic                          scalar_mem_stall_o,
  input  logic                          vector_stall_i,
  output logic [DATA_WIDTH-1:0]         vector_instruction_o,
  output logic [DATA_WIDTH-1:0]         rs1_o,
  output logic [DATA_WIDTH-1:0]         rs2_o,
  output logic                          fifo_empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);

  // Vector load (LOAD-FP major opcode) or vector store (STORE-FP major opcode).
  function automatic logic is_vmem_op(input logic [DATA_WIDTH-1:0] instr);
    logic hit;
    case (instr[6:0])
      7'b0000111: hit = 1'b1;
      7'b0100111: hit = 1'b1;
      default:    hit = 1'b0;
    endcase
    return hit;
  endfunction

  logic [DATA_WIDTH-1:0] instr_mem_r [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] rs1_mem_r   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] rs2_mem_r   [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] mem_cnt_r;

  logic             push_s;
  logic             pop_s;
  logic             mem_push_s;
  logic             mem_pop_s;
  logic [CNT_W-1:0] count_nxt_s;
  logic [CNT_W-1:0] mem_cnt_nxt_s;

  assign push_s     = instr_valid_i && (count_r != CNT_FULL);
  assign pop_s      = (count_r != CNT_ZERO) && !vector_stall_i;
  assign mem_push_s = push_s && is_vmem_op(vector_instruction_i);
  assign mem_pop_s  = pop_s && is_vmem_op(instr_mem_r[rd_ptr_r]);

  // Occupancy and memory-op count updates for one edge.
  always_comb begin
    count_nxt_s   = count_r;
    mem_cnt_nxt_s = mem_cnt_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
    case ({mem_push_s, mem_pop_s})
      2'b10:   mem_cnt_nxt_s = mem_cnt_r + CNT_ONE;
      2'b01:   mem_cnt_nxt_s = mem_cnt_r - CNT_ONE;
      default: mem_cnt_nxt_s = mem_cnt_r;
    endcase
  end

  // Pointer and counter state; flush drops any same-edge push or pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r  <= PTR_ZERO;
      rd_ptr_r  <= PTR_ZERO;
      count_r   <= CNT_ZERO;
      mem_cnt_r <= CNT_ZERO;
    end else if (flush_i) begin
      wr_ptr_r  <= PTR_ZERO;
      rd_ptr_r  <= PTR_ZERO;
      count_r   <= CNT_ZERO;
      mem_cnt_r <= CNT_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r   <= count_nxt_s;
      mem_cnt_r <= mem_cnt_nxt_s;
    end
  end

  // Entry storage; contents are never cleared, only invalidated by the pointers.
  always_ff @(posedge clk) begin
    if (push_s && !flush_i) begin
      instr_mem_r[wr_ptr_r] <= vector_instruction_i;
      rs1_mem_r[wr_ptr_r]   <= rs1_i;
      rs2_mem_r[wr_ptr_r]   <= rs2_i;
    end
  end

  // Head entry is shown ahead; an empty queue presents the all-zero no-op.
  always_comb begin
    if (count_r == CNT_ZERO) begin
      vector_instruction_o = {DATA_WIDTH{1'b0}};
      rs1_o                = {DATA_WIDTH{1'b0}};
      rs2_o                = {DATA_WIDTH{1'b0}};
    end else begin
      vector_instruction_o = instr_mem_r[rd_ptr_r];
      rs1_o                = rs1_mem_r[rd_ptr_r];
      rs2_o                = rs2_mem_r[rd_ptr_r];
    end
  end

  assign instr_ready_o      = (count_r != CNT_FULL);
  assign fifo_empty_o       = (count_r == CNT_ZERO);
  assign fill_level_o       = count_r;
  assign scalar_mem_stall_o = (scalar_load_req_i || scalar_store_req_i) &&
                              (mem_cnt_r != CNT_ZERO);

endmodule

// File: tb/tb_v_instr_issue_queue.sv
// Directed self-checking bench for v_instr_issue_queue (FIFO_DEPTH = 4, DATA_WIDTH = 32).
module tb_v_instr_issue_queue;

  logic        clk;
  logic        reset;
  logic        instr_valid_i;
  logic [31:0] vector_instruction_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic        instr_ready_o;
  logic        flush_i;
  logic        scalar_load_req_i;
  logic        scalar_store_req_i;
  logic        scalar_mem_stall_o;
  logic        vector_stall_i;
  logic [31:0] vector_instruction_o;
  logic [31:0] rs1_o;
  logic [31:0] rs2_o;
  logic        fifo_empty_o;
  logic [2:0]  fill_level_o;

  int n_checks;
  int n_fails;

  v_instr_issue_queue #(.FIFO_DEPTH(4), .DATA_WIDTH(32)) dut (
    .clk                  (clk),
    .reset                (reset),
    .instr_valid_i        (instr_valid_i),
    .vector_instruction_i (vector_instruction_i),
    .rs1_i                (rs1_i),
    .rs2_i                (rs2_i),
    .instr_ready_o        (instr_ready_o),
    .flush_i              (flush_i),
    .scalar_load_req_i    (scalar_load_req_i),
    .scalar_store_req_i   (scalar_store_req_i),
    .scalar_mem_stall_o   (scalar_mem_stall_o),
    .vector_stall_i       (vector_stall_i),
    .vector_instruction_o (vector_instruction_o),
    .rs1_o                (rs1_o),
    .rs2_o                (rs2_o),
    .fifo_empty_o         (fifo_empty_o),
    .fill_level_o         (fill_level_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_fails = n_fails + 1;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    instr_valid_i        = v;
    vector_instruction_i = ins;
    rs1_i                = a;
    rs2_i                = b;
  endtask

  task automatic check_head(input string tag, input logic [31:0] ins, input logic [31:0] a,
                            input logic [31:0] b, input logic [2:0] lvl);
    check({tag, "_instr"}, vector_instruction_o, ins);
    check({tag, "_rs1"}, rs1_o, a);
    check({tag, "_rs2"}, rs2_o, b);
    check({tag, "_fill"}, 32'(fill_level_o), 32'(lvl));
    check({tag, "_empty"}, 32'(fifo_empty_o), (lvl == 3'd0) ? 32'd1 : 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    reset = 1'b0;
    flush_i = 1'b0;
    scalar_load_req_i = 1'b0;
    scalar_store_req_i = 1'b0;
    vector_stall_i = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0);

    // Reset state
    #12;
    check_head("rst", 32'h0, 32'h0, 32'h0, 3'd0);
    check("rst_ready", 32'(instr_ready_o), 32'd1);
    scalar_load_req_i = 1'b1;
    #1;
    check("rst_stall", 32'(scalar_mem_stall_o), 32'd0);
    scalar_load_req_i = 1'b0;
    #2;
    reset = 1'b1;

    // Single entry through an unstalled vector core
    tick();
    drive(1'b1, 32'h0000_0057, 32'h11, 32'h22);
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    check_head("single_a", 32'h0000_0057, 32'h11, 32'h22, 3'd1);
    tick();
    check_head("single_b", 32'h0, 32'h0, 32'h0, 3'd0);

    // Fill while stalled, fifth entry held off until the stall releases
    vector_stall_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h100 + 32'(i), 32'h200 + 32'(i), 32'(i));
      tick();
    end
    check("full_ready", 32'(instr_ready_o), 32'd0);
    check_head("full", 32'h100, 32'h200, 32'h0, 3'd4);
    drive(1'b1, 32'h104, 32'h204, 32'h4);
    tick();
    check_head("full_hold", 32'h100, 32'h200, 32'h0, 3'd4);
    vector_stall_i = 1'b0;
    tick();
    check_head("release", 32'h101, 32'h201, 32'h1, 3'd3);
    check("release_ready", 32'(instr_ready_o), 32'd1);
    vector_stall_i = 1'b1;
    tick();
    check_head("fifth_in", 32'h101, 32'h201, 32'h1, 3'd4);
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    vector_stall_i = 1'b0;
    for (int i = 1; i < 5; i++) begin
      check_head("drain", 32'h100 + 32'(i), 32'h200 + 32'(i), 32'(i), 3'(5 - i));
      tick();
    end
    check_head("drained", 32'h0, 32'h0, 32'h0, 3'd0);

    // Streaming push+pop across pointer wrap
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 32'h300 + 32'(k), 32'h310 + 32'(k), 32'h320 + 32'(k));
      tick();
      check_head("stream", 32'h300 + 32'(k), 32'h310 + 32'(k), 32'h320 + 32'(k), 3'd1);
    end
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    tick();
    check_head("stream_end", 32'h0, 32'h0, 32'h0, 3'd0);

    // Full queue: pop first, then push and pop in the same edge
    vector_stall_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h400 + 32'(i), 32'h410 + 32'(i), 32'h420 + 32'(i));
      tick();
    end
    check("pp_full_ready", 32'(instr_ready_o), 32'd0);
    vector_stall_i = 1'b0;
    drive(1'b1, 32'h404, 32'h414, 32'h424);
    tick();
    check_head("pp_pop", 32'h401, 32'h411, 32'h421, 3'd3);
    tick();
    check_head("pp_both1", 32'h402, 32'h412, 32'h422, 3'd3);
    drive(1'b1, 32'h405, 32'h415, 32'h425);
    tick();
    check_head("pp_both2", 32'h403, 32'h413, 32'h423, 3'd3);
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    tick();
    check_head("pp_d1", 32'h404, 32'h414, 32'h424, 3'd2);
    tick();
    check_head("pp_d2", 32'h405, 32'h415, 32'h425, 3'd1);
    tick();
    check_head("pp_d3", 32'h0, 32'h0, 32'h0, 3'd0);

    // Vector load, vector store, and a non-memory op against scalar requests
    for (int t = 0; t < 3; t++) begin
      vector_stall_i     = 1'b1;
      scalar_load_req_i  = (t != 1);
      scalar_store_req_i = (t == 1);
      drive(1'b1, (t == 0) ? 32'h0200_6007 : ((t == 1) ? 32'h0200_6027 : 32'h0000_0057),
            32'h55, 32'h66);
      #1;
      check("mem_pre", 32'(scalar_mem_stall_o), 32'd0);
      tick();
      drive(1'b0, 32'h0, 32'h0, 32'h0);
      check("mem_queued", 32'(scalar_mem_stall_o), (t == 2) ? 32'd0 : 32'd1);
      tick();
      check("mem_held", 32'(scalar_mem_stall_o), (t == 2) ? 32'd0 : 32'd1);
      vector_stall_i = 1'b0;
      #1;
      check("mem_popping", 32'(scalar_mem_stall_o), (t == 2) ? 32'd0 : 32'd1);
      tick();
      check("mem_popped", 32'(scalar_mem_stall_o), 32'd0);
      check("mem_empty", 32'(fifo_empty_o), 32'd1);
    end
    scalar_load_req_i  = 1'b0;
    scalar_store_req_i = 1'b0;

    // Flush with three queued and a simultaneous push
    vector_stall_i = 1'b1;
    drive(1'b1, 32'h0200_6007, 32'h1, 32'h2);
    tick();
    drive(1'b1, 32'h0000_0057, 32'h3, 32'h4);
    tick();
    drive(1'b1, 32'h0200_6027, 32'h5, 32'h6);
    tick();
    scalar_load_req_i = 1'b1;
    #1;
    check("flush_pre_stall", 32'(scalar_mem_stall_o), 32'd1);
    check("flush_pre_fill", 32'(fill_level_o), 32'd3);
    drive(1'b1, 32'h0200_6007, 32'h7, 32'h8);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    check_head("flush", 32'h0, 32'h0, 32'h0, 3'd0);
    check("flush_stall", 32'(scalar_mem_stall_o), 32'd0);

    // Asynchronous reset with two entries queued
    drive(1'b1, 32'h500, 32'h501, 32'h502);
    tick();
    drive(1'b1, 32'h0200_6007, 32'h503, 32'h504);
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    check_head("pre_rst", 32'h500, 32'h501, 32'h502, 3'd2);
    check("pre_rst_stall", 32'(scalar_mem_stall_o), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_head("async_rst", 32'h0, 32'h0, 32'h0, 3'd0);
    check("async_rst_ready", 32'(instr_ready_o), 32'd1);
    check("async_rst_stall", 32'(scalar_mem_stall_o), 32'd0);
    #3;
    reset = 1'b1;
    scalar_load_req_i = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
